// File: rtl/core_mem_pkg.sv
// core_mem_pkg
// Shared types for the core's memory-facing logic.
//   arb_state_e : arbiter phase (IDLE / ADDR / RESP)
//   arb_owner_e : which port owns the bus transaction in flight
//   mem_req_t   : one registered bus request (we, be, addr, wdata)
//   BE_WORD     : full-word byte-enable mask, used for instruction fetches
package core_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam logic [3:0] BE_WORD = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        DM   = 2'd2
    } arb_owner_e;

    typedef struct packed {
        logic                  we;
        logic [3:0]            be;
        logic [MEM_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory bus between the fetch (IF) port and the
// memory-stage data (DM) port. Data requests have priority, but a fetch that
// has lost arbitration MAX_IF_WAIT times in a row is forced to win next.
// Exactly one bus transaction is outstanding at a time:
//   IDLE -> ADDR (bus_req_o high until bus_gnt_i) -> RESP (until bus_rvalid_i)
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   if_req_i/if_addr_i/if_kill_i fetch request, address, branch flush
//   if_gnt_o/if_rvalid_o/if_rdata_o   fetch grant / response
//   dm_req_i/we/be/addr/wdata    data request fields
//   dm_gnt_o/dm_rvalid_o/dm_rdata_o   data grant / response
//   bus_req_o/we/be/addr/wdata   registered memory request
//   bus_gnt_i/bus_rvalid_i/bus_rdata_i memory address-phase accept / response
module mem_port_arbiter
    import core_mem_pkg::*;
#(
    parameter int MAX_IF_WAIT = 4,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_kill_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [3:0]        dm_be_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [31:0]       dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [31:0]       dm_rdata_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_be_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [31:0]       bus_rdata_i
);

    localparam logic [3:0] MAX_WAIT = 4'(MAX_IF_WAIT);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       kill_pend_q, kill_pend_d;
    logic       bus_req_q, bus_req_d;
    mem_req_t   req_q, req_d;

    logic if_forced;
    logic pick_dm;
    logic pick_if;
    logic own_if;

    // A fetch that has waited MAX_IF_WAIT lost rounds overrides data priority.
    assign if_forced = if_req_i && (starve_cnt_q == MAX_WAIT);
    assign pick_dm   = dm_req_i && !if_forced;
    assign pick_if   = if_req_i && !pick_dm;
    assign own_if    = (owner_q == IF);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        kill_pend_d  = kill_pend_q;
        bus_req_d    = bus_req_q;
        req_d        = req_q;
        case (state_q)
            IDLE: begin
                if (pick_dm) begin
                    owner_d   = DM;
                    req_d.we    = dm_we_i;
                    req_d.be    = dm_be_i;
                    req_d.addr  = MEM_ADDR_W'(dm_addr_i);
                    req_d.wdata = dm_wdata_i;
                    bus_req_d = 1'b1;
                    state_d   = ADDR;
                end else if (pick_if) begin
                    owner_d   = IF;
                    req_d.we    = 1'b0;
                    req_d.be    = BE_WORD;
                    req_d.addr  = MEM_ADDR_W'(if_addr_i);
                    req_d.wdata = '0;
                    bus_req_d = 1'b1;
                    state_d   = ADDR;
                end
                // Only IDLE-cycle losses count towards starvation.
                if (pick_if) begin
                    starve_cnt_d = '0;
                end else if (if_req_i && (starve_cnt_q < MAX_WAIT)) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end
            end
            ADDR: begin
                if (if_kill_i && own_if) begin
                    kill_pend_d = 1'b1;
                end
                if (bus_gnt_i) begin
                    bus_req_d = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (bus_rvalid_i) begin
                    state_d     = IDLE;
                    owner_d     = NONE;
                    kill_pend_d = 1'b0;
                end else if (if_kill_i && own_if) begin
                    kill_pend_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = NONE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= NONE;
            starve_cnt_q <= '0;
            kill_pend_q  <= 1'b0;
            bus_req_q    <= 1'b0;
            req_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            kill_pend_q  <= kill_pend_d;
            bus_req_q    <= bus_req_d;
            req_q        <= req_d;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = req_q.we;
    assign bus_be_o    = req_q.be;
    assign bus_addr_o  = ADDR_W'(req_q.addr);
    assign bus_wdata_o = req_q.wdata;

    // Grants and responses are the bus handshakes steered to the owner;
    // stray handshakes outside their phase are ignored.
    assign if_gnt_o = (state_q == ADDR) && own_if && bus_gnt_i;
    assign dm_gnt_o = (state_q == ADDR) && (owner_q == DM) && bus_gnt_i;

    // A kill arriving together with the response suppresses it as well.
    assign if_rvalid_o = (state_q == RESP) && own_if && bus_rvalid_i
                         && !kill_pend_q && !if_kill_i;
    assign dm_rvalid_o = (state_q == RESP) && (owner_q == DM) && bus_rvalid_i;

    assign if_rdata_o = bus_rdata_i;
    assign dm_rdata_o = bus_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import core_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        if_req_i, if_kill_i, if_gnt_o, if_rvalid_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
    logic        bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_IF_WAIT(4), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    // Expected bus transaction, pushed when a request is driven.
    typedef struct {
        bit          is_dm;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];

    // Table vector: one isolated request plus the memory's timing for it.
    // kill: 0 none, 1 pulse one cycle before rvalid, 2 with rvalid, 3 in ADDR.
    typedef struct {
        bit          is_dm;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rsp_dly;
        int          kill;
    } vec_t;

    vec_t vecs[9];

    // Requesters must hold their request until granted.
    logic if_req_prev, if_gnt_prev, dm_req_prev, dm_gnt_prev;
    always @(posedge clk) begin
        if (rst_i) begin
            if_req_prev <= 1'b0; if_gnt_prev <= 1'b0;
            dm_req_prev <= 1'b0; dm_gnt_prev <= 1'b0;
        end else begin
            if (if_req_prev && !if_gnt_prev && !if_req_i)
                $error("fetch request dropped before grant");
            if (dm_req_prev && !dm_gnt_prev && !dm_req_i)
                $error("data request dropped before grant");
            if_req_prev <= if_req_i; if_gnt_prev <= if_gnt_o;
            dm_req_prev <= dm_req_i; dm_gnt_prev <= dm_gnt_o;
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic push_if(input logic [31:0] addr, input logic [31:0] rdata);
        exp_t e;
        e.is_dm = 1'b0; e.we = 1'b0; e.be = 4'hF;
        e.addr = addr; e.wdata = '0; e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic push_dm(input bit we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata);
        exp_t e;
        e.is_dm = 1'b1; e.we = we; e.be = be;
        e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Acts as the memory for one transaction and checks it against the
    // scoreboard head. Starts and ends at a falling edge.
    task automatic serve(input int gnt_dly, input int rsp_dly, input int kill, input bit drop);
        exp_t e;
        int   n;
        bit   exp_if_rv;
        n = 0;
        while (!bus_req_o && n < 20) begin
            tick;
            n++;
        end
        if (!bus_req_o) begin
            chk("bus_req_timeout", {31'd0, bus_req_o}, 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            chk("unexpected_bus_req", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        $display("txn %s we=%0d be=%h addr=%h wdata=%h rdata=%h gnt_dly=%0d rsp_dly=%0d kill=%0d",
                 e.is_dm ? "DM" : "IF", e.we, e.be, e.addr, e.wdata, e.rdata, gnt_dly, rsp_dly, kill);
        chk("bus_addr", bus_addr_o, e.addr);
        chk("bus_we", {31'd0, bus_we_o}, {31'd0, e.we});
        chk("bus_be", {28'd0, bus_be_o}, {28'd0, e.be});
        chk("bus_wdata", bus_wdata_o, e.wdata);
        for (int i = 0; i < gnt_dly; i++) begin
            if (kill == 3 && i == 0) if_kill_i = 1'b1;
            #1;
            chk("stall_req", {31'd0, bus_req_o}, 32'd1);
            chk("stall_addr", bus_addr_o, e.addr);
            chk("stall_gnts", {30'd0, if_gnt_o, dm_gnt_o}, 32'd0);
            tick;
            if_kill_i = 1'b0;
        end
        bus_gnt_i = 1'b1;
        #1;
        chk("if_gnt", {31'd0, if_gnt_o}, {31'd0, !e.is_dm});
        chk("dm_gnt", {31'd0, dm_gnt_o}, {31'd0, e.is_dm});
        tick;
        bus_gnt_i = 1'b0;
        if (drop) begin
            if (e.is_dm) dm_req_i = 1'b0;
            else         if_req_i = 1'b0;
        end
        #1;
        chk("req_drop_after_gnt", {31'd0, bus_req_o}, 32'd0);
        chk("gnt_after_accept", {30'd0, if_gnt_o, dm_gnt_o}, 32'd0);
        for (int i = 0; i < rsp_dly; i++) begin
            if (kill == 1 && i == rsp_dly - 1) if_kill_i = 1'b1;
            #1;
            chk("early_rvalid", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'd0);
            tick;
            if_kill_i = 1'b0;
        end
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = e.rdata;
        if (kill == 2) if_kill_i = 1'b1;
        #1;
        exp_if_rv = !e.is_dm && (kill == 0);
        chk("if_rvalid", {31'd0, if_rvalid_o}, {31'd0, exp_if_rv});
        chk("dm_rvalid", {31'd0, dm_rvalid_o}, {31'd0, e.is_dm});
        chk("if_rdata", if_rdata_o, e.rdata);
        chk("dm_rdata", dm_rdata_o, e.rdata);
        tick;
        bus_rvalid_i = 1'b0;
        if_kill_i    = 1'b0;
        #1;
        chk("idle_bubble", {31'd0, bus_req_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        if_req_i = 0; if_addr_i = 0; if_kill_i = 0;
        dm_req_i = 0; dm_we_i = 0; dm_be_i = 0; dm_addr_i = 0; dm_wdata_i = 0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;

        //                   dm  we  be     addr          wdata         rdata         g  r  kill
        vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,        32'h0000_0013, 1, 2, 0};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_8004, 32'h0,        32'h1122_3344, 0, 1, 0};
        vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_8008, 32'hCAFE_F00D, 32'h0,        2, 0, 0};
        vecs[3] = '{1'b0, 1'b0, 4'hF, 32'h0000_0180, 32'h0,        32'hAAAA_5555, 1, 2, 1};
        vecs[4] = '{1'b0, 1'b0, 4'hF, 32'h0000_0300, 32'h0,        32'h0010_0093, 1, 1, 0};
        vecs[5] = '{1'b0, 1'b0, 4'hF, 32'h0000_0304, 32'h0,        32'h0000_0067, 0, 1, 2};
        vecs[6] = '{1'b0, 1'b0, 4'hF, 32'h0000_0308, 32'h0,        32'h0000_00EF, 2, 1, 3};
        vecs[7] = '{1'b1, 1'b0, 4'hF, 32'h0000_800C, 32'h0,        32'h5A5A_A5A5, 1, 2, 1};
        vecs[8] = '{1'b0, 1'b0, 4'hF, 32'h0000_030C, 32'h0,        32'h0000_0073, 0, 0, 0};

        // Reset state.
        tick; tick;
        chk("rst_bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("rst_bus_fields", {bus_we_o, bus_be_o, bus_addr_o[26:0]}, 32'd0);
        chk("rst_bus_wdata", bus_wdata_o, 32'd0);
        chk("rst_gnt_rvalid", {28'd0, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o}, 32'd0);
        rst_i = 1'b0;

        // Isolated single-port transactions.
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].is_dm) begin
                dm_req_i = 1'b1; dm_we_i = vecs[v].we; dm_be_i = vecs[v].be;
                dm_addr_i = vecs[v].addr; dm_wdata_i = vecs[v].wdata;
                push_dm(vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata, vecs[v].rdata);
            end else begin
                if_req_i = 1'b1; if_addr_i = vecs[v].addr;
                push_if(vecs[v].addr, vecs[v].rdata);
            end
            #1;
            chk("req_not_early", {31'd0, bus_req_o}, 32'd0);
            tick;
            chk("req_latency", {31'd0, bus_req_o}, 32'd1);
            serve(vecs[v].gnt_dly, vecs[v].rsp_dly, vecs[v].kill, 1'b1);
        end

        // Simultaneous requests: data store first, then the fetch.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0200;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'hF;
        dm_addr_i = 32'h0000_8000; dm_wdata_i = 32'hDEAD_BEEF;
        push_dm(1'b1, 4'hF, 32'h0000_8000, 32'hDEAD_BEEF, 32'h0);
        push_if(32'h0000_0200, 32'h0000_0013);
        tick;
        chk("starve_after_loss", {28'd0, dut.starve_cnt_q}, 32'd1);
        serve(1, 1, 0, 1'b1);
        chk("starve_holds", {28'd0, dut.starve_cnt_q}, 32'd1);
        serve(1, 1, 0, 1'b1);
        chk("starve_cleared", {28'd0, dut.starve_cnt_q}, 32'd0);

        // Starvation: data held continuously, fetch wins on the 5th round.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0400;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF;
        dm_addr_i = 32'h0000_9000; dm_wdata_i = 32'h0;
        for (int k = 0; k < 4; k++) push_dm(1'b0, 4'hF, 32'h0000_9000, 32'h0, 32'h100 + 32'(k));
        push_if(32'h0000_0400, 32'h0000_0033);
        push_dm(1'b0, 4'hF, 32'h0000_9000, 32'h0, 32'h0000_0777);
        for (int k = 0; k < 4; k++) serve(0, 1, 0, 1'b0);
        chk("starve_saturated", {28'd0, dut.starve_cnt_q}, 32'd4);
        serve(0, 1, 0, 1'b1);
        serve(0, 1, 0, 1'b1);

        // Stalled grant; a data request arriving meanwhile waits its turn.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0500;
        push_if(32'h0000_0500, 32'h0000_0B0B);
        tick;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'hC;
        dm_addr_i = 32'h0000_A000; dm_wdata_i = 32'h1234_5678;
        push_dm(1'b1, 4'hC, 32'h0000_A000, 32'h1234_5678, 32'h0);
        serve(6, 1, 0, 1'b1);
        serve(1, 1, 0, 1'b1);

        // Reset while waiting for the response; late response is dropped.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0600;
        tick;
        bus_gnt_i = 1'b1;
        tick;
        bus_gnt_i = 1'b0; if_req_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("midrst_bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("midrst_bus_fields", {bus_we_o, bus_be_o, bus_addr_o[26:0]}, 32'd0);
        chk("midrst_gnt_rvalid", {28'd0, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o}, 32'd0);
        tick;
        rst_i = 1'b0;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'hBAD0_BAD0;
        #1;
        chk("late_rvalid_dropped", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'd0);
        chk("state_idle", {30'd0, dut.state_q}, {30'd0, IDLE});
        tick;
        bus_rvalid_i = 1'b0;
        // Stray grant in IDLE is ignored.
        bus_gnt_i = 1'b1;
        #1;
        chk("stray_gnt", {30'd0, if_gnt_o, dm_gnt_o}, 32'd0);
        tick;
        bus_gnt_i = 1'b0;
        #1;
        chk("stray_gnt_no_req", {31'd0, bus_req_o}, 32'd0);
        if_req_i = 1'b1; if_addr_i = 32'h0000_0700;
        push_if(32'h0000_0700, 32'h0000_0013);
        serve(1, 2, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
